mixcolumns_control: RTL and testbench
=====================================

Name: mixcolumns_control

Overview:
- Sequencer for the byte-serial AES MixColumns datapath.
- After a start command it steps through all 64 GF(2^8) multiply-accumulate operations (16 output bytes x 4 terms), one per clock.
- Each step supplies the input-state byte index, coefficient-table index and accumulator index to the shared function unit, plus a write enable.
- Reports busy and done to the enclosing MixColumns top.

Parameters:
- none (4x4 byte state, 4 terms per output byte, fixed).

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- start  input  1  request new MixColumns pass; sampled only in IDLE or DONE
- out_idx  output  4  accumulator byte index s[out_idx] read and written this step
- in_idx  output  4  input-state byte index fed to function unit
- coef_idx  output  4  coefficient-table index y[coef_idx] fed to function unit
- acc_we  output  1  accumulator write enable: s[out_idx] <= function-unit result
- step  output  6  current step counter 0..63 (debug/observability)
- busy  output  1  high while steps are being issued
- done  output  1  high from completion until next accepted start or reset

Behaviour:
- States: IDLE, RUN, DONE. Reset (synchronous, active-high; clock clk) -> IDLE, step=0, busy=0, done=0, acc_we=0, all indices 0.
- IDLE/DONE + start=1 -> RUN next edge, step=0, done cleared. The enclosing top latches the input state and clears the accumulators in the start cycle, so the first step issues the cycle after start.
- RUN: one step per cycle, acc_we=1, busy=1.
- Step counter decomposes as step = {c[1:0], r[1:0], k[1:0]}; c = column, r = row, k = term (innermost).
  - out_idx = {c,r} = step[5:2]
  - in_idx = {c,k} = {step[5:4], step[1:0]}
  - coef_idx = {r,k} = step[3:0]
  - Indices are combinational from the step register and valid in the same cycle as acc_we.
- Step increments each RUN cycle. After step 63 is issued: -> DONE, busy=0, acc_we=0, done=1, step returns to 0.
- Total: start at cycle T -> steps issued T+1..T+64 -> done=1 from T+65.
- start while RUN: ignored; no restart and no counter disturbance.
- start in DONE: accepted exactly as in IDLE (back-to-back passes allowed).
- reset has priority over start in the same cycle.
- reset mid-RUN aborts the pass: IDLE next edge, acc_we=0, no done.
- acc_we never asserts outside RUN. Indices are 0 in IDLE/DONE.
- No wrap of step beyond 63. 6-bit counter, terminal-count compare at 63.

Test Plan:
- Reset then idle 10 cycles -> busy=0, done=0, acc_we=0, out_idx=in_idx=coef_idx=0 throughout.
- Pulse start at cycle T -> at T+1: step=0, acc_we=1, out_idx=0, in_idx=0, coef_idx=0. At T+6 (step 5): out_idx=1, in_idx=1, coef_idx=5. At T+28 (step 27): out_idx=6, in_idx=7, coef_idx=11.
- Completion timing -> at T+64: step=63, out_idx=15, in_idx=15, coef_idx=15, acc_we=1. At T+65: acc_we=0, busy=0, done=1. done stays 1 until next start.
- start held high during RUN, and a second start pulse at T+30 -> sequence unaffected, done still at T+65. A start in DONE restarts with done dropping the next cycle.
- Reset asserted at T+20 -> IDLE next edge, acc_we=0, done=0. A new start then gives a full 64-step pass.
- Integration with function unit and y table {2,3,1,1, 1,2,3,1, 1,1,2,3, 3,1,1,2}: column bytes db,13,53,45 -> 8e,4d,a1,bc; column 01,01,01,01 -> 01,01,01,01.

Source files
------------

// File: rtl/mixcolumns_control.sv
// Step sequencer for the byte-serial AES MixColumns datapath. It issues 64
// multiply-accumulate steps, one per clock, and then reports done.
//
// state  | meaning
// S_IDLE | waiting for start, no steps issued
// S_RUN  | issuing one MAC step per cycle, step = {col, row, term}
// S_DONE | pass complete, done held until the next start or reset
module mixcolumns_control (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  output logic [3:0] out_idx,
  output logic [3:0] in_idx,
  output logic [3:0] coef_idx,
  output logic       acc_we,
  output logic [5:0] step,
  output logic       busy,
  output logic       done
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  localparam logic [5:0] STEP_LAST = 6'd63;

  state_t     r_state;
  logic [5:0] r_step;
  logic       r_acc_we;
  logic       r_busy;
  logic       r_done;
  logic       w_last;

  assign w_last = (r_step == STEP_LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_step   <= 6'd0;
      r_acc_we <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (start) begin
            r_state  <= S_RUN;
            r_step   <= 6'd0;
            r_acc_we <= 1'b1;
            r_busy   <= 1'b1;
            r_done   <= 1'b0;
          end
        end
        S_RUN: begin
          // start is deliberately ignored here; a pass always runs to completion
          if (w_last) begin
            r_state  <= S_DONE;
            r_step   <= 6'd0;
            r_acc_we <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b1;
          end else begin
            r_step   <= r_step + 6'd1;
          end
        end
        default: begin
          r_state  <= S_IDLE;
          r_step   <= 6'd0;
          r_acc_we <= 1'b0;
          r_busy   <= 1'b0;
          r_done   <= 1'b0;
        end
      endcase
    end
  end

  // Gated so the function unit sees zero indices whenever no step is issued.
  assign out_idx  = r_acc_we ? r_step[5:2] : 4'd0;
  assign in_idx   = r_acc_we ? {r_step[5:4], r_step[1:0]} : 4'd0;
  assign coef_idx = r_acc_we ? r_step[3:0] : 4'd0;

  assign acc_we = r_acc_we;
  assign step   = r_step;
  assign busy   = r_busy;
  assign done   = r_done;

endmodule

// File: tb/tb_mixcolumns_control.sv
// Self-checking bench for mixcolumns_control: pass-position reference model,
// directed timing scenarios, random start/reset traffic and a GF(2^8) datapath.
module tb_mixcolumns_control;

  logic       clk;
  logic       reset;
  logic       start;
  logic [3:0] out_idx;
  logic [3:0] in_idx;
  logic [3:0] coef_idx;
  logic       acc_we;
  logic [5:0] step;
  logic       busy;
  logic       done;

  mixcolumns_control dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .out_idx  (out_idx),
    .in_idx   (in_idx),
    .coef_idx (coef_idx),
    .acc_we   (acc_we),
    .step     (step),
    .busy     (busy),
    .done     (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: position within the pass (-1 = not running) plus done flag.
  int m_pos;
  bit m_done;

  logic [7:0] ytab [16];
  logic [7:0] st_in [16];
  logic [7:0] acc [16];
  bit         fu_en;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  // One clock: check outputs against the model mid-cycle, then drive the next inputs.
  task automatic cycle(input bit st_i, input bit rs_i);
    int p, c, r, k;
    @(negedge clk);
    p = (m_pos < 0) ? 0 : m_pos;
    c = p / 16;
    r = (p / 4) % 4;
    k = p % 4;
    chk("busy",   busy,   (m_pos >= 0));
    chk("acc_we", acc_we, (m_pos >= 0));
    chk("done",   done,   m_done);
    chk("step",   step,   p);
    chk("out_idx",  out_idx,  (m_pos < 0) ? 0 : c * 4 + r);
    chk("in_idx",   in_idx,   (m_pos < 0) ? 0 : c * 4 + k);
    chk("coef_idx", coef_idx, (m_pos < 0) ? 0 : r * 4 + k);
    if (fu_en && acc_we === 1'b1)
      acc[out_idx] = acc[out_idx] ^ gmul(st_in[in_idx], ytab[coef_idx]);
    start = st_i;
    reset = rs_i;
    if (rs_i) begin
      m_pos = -1; m_done = 0;
    end else if (m_pos >= 0) begin
      if (m_pos == 63) begin m_pos = -1; m_done = 1; end
      else m_pos = m_pos + 1;
    end else if (st_i) begin
      m_pos = 0; m_done = 0;
    end
  endtask

  // Cycles from the start cycle until done is seen (65 expected), bounded.
  task automatic pass_len(input string tag, input bit hold_start, input int extra_pulse);
    int n = 0;
    cycle(1'b1, 1'b0);
    while (n < 200) begin
      cycle(hold_start || (n + 1 == extra_pulse), 1'b0);
      n++;
      if (done === 1'b1) break;
    end
    chk(tag, n, 65);
  endtask

  function automatic logic [7:0] mc_row(input logic [7:0] a0, a1, a2, a3);
    return xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
  endfunction

  initial begin
    ytab = '{8'h02, 8'h03, 8'h01, 8'h01, 8'h01, 8'h02, 8'h03, 8'h01,
             8'h01, 8'h01, 8'h02, 8'h03, 8'h03, 8'h01, 8'h01, 8'h02};
    fu_en = 0;
    reset = 1'b1;
    start = 1'b0;
    m_pos = -1;
    m_done = 0;
    repeat (2) @(negedge clk);

    // reset release, idle for 10 cycles
    cycle(1'b0, 1'b0);
    repeat (10) cycle(1'b0, 1'b0);

    // single pulse, then a start in DONE restarts
    pass_len("len_pulse", 1'b0, 0);
    repeat (3) cycle(1'b0, 1'b0);
    pass_len("len_restart_in_done", 1'b0, 0);

    // extra start at T+30 and start held high throughout the run
    pass_len("len_pulse_t30", 1'b0, 30);
    pass_len("len_start_held", 1'b1, 0);
    cycle(1'b0, 1'b0);

    // reset asserted at T+20 aborts; a fresh start then runs a full pass
    cycle(1'b1, 1'b0);
    repeat (19) cycle(1'b0, 1'b0);
    cycle(1'b0, 1'b1);
    cycle(1'b0, 1'b0);
    chk("abort_done", done, 1'b0);
    chk("abort_busy", busy, 1'b0);
    repeat (3) cycle(1'b0, 1'b0);
    pass_len("len_after_abort", 1'b0, 0);

    // reset wins over start in the same cycle
    cycle(1'b1, 1'b1);
    cycle(1'b0, 1'b0);
    chk("reset_prio_busy", busy, 1'b0);

    // datapath integration: known vectors plus two random columns
    st_in = '{8'hdb, 8'h13, 8'h53, 8'h45, 8'h01, 8'h01, 8'h01, 8'h01,
              8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    for (int i = 8; i < 16; i++) st_in[i] = 8'($urandom_range(0, 255));
    for (int i = 0; i < 16; i++) acc[i] = 8'h00;
    fu_en = 1;
    pass_len("len_integration", 1'b0, 0);
    fu_en = 0;
    chk("mc_c0_r0", acc[0], 8'h8e);
    chk("mc_c0_r1", acc[1], 8'h4d);
    chk("mc_c0_r2", acc[2], 8'ha1);
    chk("mc_c0_r3", acc[3], 8'hbc);
    for (int i = 4; i < 8; i++) chk("mc_c1", acc[i], 8'h01);
    for (int c = 2; c < 4; c++) begin
      for (int r = 0; r < 4; r++)
        chk("mc_rand", acc[c*4+r], mc_row(st_in[c*4+r], st_in[c*4+(r+1)%4],
                                          st_in[c*4+(r+2)%4], st_in[c*4+(r+3)%4]));
    end

    // random start/reset traffic
    for (int i = 0; i < 4000; i++)
      cycle(($urandom_range(0, 19) == 0), ($urandom_range(0, 299) == 0));

    cycle(1'b0, 1'b0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
